wb_sram_responder: RTL and testbench
====================================

Name: wb_sram_responder

Overview:
- Wishbone classic slave that answers the NoC gateway's 32-bit bus cycles and stores the data in the 256x8 gf180 SRAM macro.
- Each 32-bit word is serialised into four byte accesses on the SRAM, little-endian.
- Supports reads for readback and verification.
- Sits between the housekeeping bus master and the SRAM, replacing the combinational ack/CEN glue.

Parameters:
- BASE_ADR, 32'h0000_1000, byte address of SRAM byte 0.
- SRAM_AW, 8, SRAM address width; window spans 2**SRAM_AW bytes (64 words).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  bus cycle valid
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_sel_i  in  4  byte-lane enables; bit k selects wbs_dat_i[8k+7:8k]
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_dat_o  out  32  read data, valid while wbs_ack_o = 1
- wbs_ack_o  out  1  single-cycle acknowledge
- wbs_err_o  out  1  single-cycle error; stuck at 0 unless WB_RESP_ERR_EN is defined
- sram_cen  out  1  SRAM chip enable, active low
- sram_wen  out  8  SRAM bit write mask, active low
- sram_a  out  SRAM_AW  SRAM byte address
- sram_d  out  8  SRAM write data
- sram_q  in  8  SRAM read data, valid one clk after the read issue

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, reset_n.
- Reset values (async, on any cycle, including mid-transfer):
  - wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0
  - sram_cen = 1, sram_wen = 8'hFF, sram_a = 0, sram_d = 0
  - state = IDLE, lane counter = 0
- Address map:
  - off = wbs_adr_i - BASE_ADR, computed in 32 bits.
  - In range when off < 2**SRAM_AW.
  - Word index = off[SRAM_AW-1:2]; off[1:0] ignored (word aligned).
  - Byte address = {word index, lane[1:0]}.
- IDLE:
  - On cyc & stb, latch adr, dat, sel and we, clear lane, then go to WR (we = 1) or RD (we = 0).
  - An out-of-range request goes to ACK with no SRAM activity; see the optional feature.
- WR, lane 0..3:
  - sram_a = byte address, sram_d = latched data byte for that lane.
  - sram_cen = !sel[lane], sram_wen = 8'h00 when sel[lane] is set.
  - Deselected lanes still take their cycle; latency is fixed.
  - After lane 3, go to ACK.
- RD, lane 0..3:
  - cen = 0, wen = 8'hFF, issue byte address per lane.
  - Capture sram_q into byte lane-1 of the read buffer each cycle.
  - RD_LAST: capture byte 3, cen = 1, then ACK.
- ACK:
  - Assert wbs_ack_o for exactly one cycle; wbs_dat_o = read buffer (0 for writes).
  - Return to IDLE.
  - If stb is still high in the following IDLE cycle, it is a new request.
- Latency, counted from the edge that samples cyc & stb:
  - write: ack high in the 5th cycle after that edge
  - read: ack high in the 6th cycle after that edge
- SRAM idle: sram_cen = 1 and sram_wen = 8'hFF in every state except active WR/RD lanes.
- Abort: cyc low in any WR/RD/RD_LAST cycle → IDLE next edge, no ack. Bytes already written stay written.
- sel = 4'b0000 write: no SRAM access, still acked.
- Address wrap: never wraps into the window; off is unsigned, so adr < BASE_ADR is out of range.

Optional Feature:
- Macro: WB_RESP_ERR_EN.
- Defined:
  - An out-of-range request asserts wbs_err_o instead of wbs_ack_o for one cycle, in the cycle after sampling.
  - wbs_dat_o = 0 during that cycle.
- Undefined:
  - wbs_err_o is tied to 0.
  - Out-of-range requests are acked the cycle after sampling; writes are dropped, reads return 32'h0.

Decomposition:
- Package noc_wb_pkg:
  - state enum {IDLE, WR, RD, RD_LAST, ACK}
  - SRAM_BASE = 32'h1000
  - lane-width constant 2
  - WB_DW = 32
- Sub-modules: none required. The byte-lane sequencer stays inline, since it is tightly coupled to the FSM.

Test Plan:
- Write adr 0x1004, dat 0xA1B2C3D4, sel 4'hF → SRAM bytes 4..7 = D4,C3,B2,A1; ack one cycle, 5 cycles after sampling.
- Read adr 0x1004 after the above → wbs_dat_o = 0xA1B2C3D4 with ack, 6 cycles after sampling; sram_wen stays 8'hFF throughout.
- Write adr 0x1008, dat 0x11223344, sel 4'b0101 onto a word preset to 0xFFFFFFFF → read returns 0xFF22FF44; cen high on lanes 1 and 3.
- Write adr 0x10FC, dat 0xDEADBEEF, then read adr 0x1100:
  - 0x10FC: bytes 252..255 written.
  - 0x1100, macro off: ack with dat 0.
  - 0x1100, macro on: err one cycle, no ack, SRAM untouched.
- Drop cyc during write lane 2 → no ack, bytes 0..1 written, bytes 2..3 unchanged, IDLE next cycle.
- Assert reset_n low mid-read → outputs reach reset values with no clk edge; the next read after release completes normally.

Source files
------------

// File: rtl/noc_wb_pkg.sv
// Shared types and constants for the Wishbone-to-SRAM byte-serialising responder.
package noc_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_LAST,
    ACK
  } state_e;

  localparam logic [31:0] SRAM_BASE = 32'h0000_1000;
  localparam int unsigned LANE_W    = 2;
  localparam int unsigned WB_DW     = 32;

endpackage

// File: rtl/wb_sram_responder.sv
// Wishbone classic slave that serialises each 32-bit word into four little-endian SRAM byte
// accesses. Define WB_RESP_ERR_EN to answer out-of-window requests with wbs_err_o.
module wb_sram_responder
  import noc_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = SRAM_BASE,
  parameter int unsigned SRAM_AW  = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  output logic [WB_DW-1:0]   wbs_dat_o,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic               sram_cen,
  output logic [7:0]         sram_wen,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [7:0]         sram_d,
  input  logic [7:0]         sram_q
);

  localparam int unsigned WordW   = SRAM_AW - LANE_W;
  localparam logic [31:0] WinSize = 32'(1) << SRAM_AW;

  state_e             state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d, prev_lane;
  logic [WordW-1:0]   word_q, word_d;
  logic [WB_DW-1:0]   wdat_q, wdat_d;
  logic [WB_DW-1:0]   rbuf_q, rbuf_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic               oor_q, oor_d;
  logic [31:0]        off;
  logic               req;

  // Unsigned subtraction: addresses below the base wrap high and land out of range.
  assign off       = wbs_adr_i - BASE_ADR;
  assign req       = wbs_cyc_i & wbs_stb_i;
  assign prev_lane = lane_q - 1'b1;
  assign sram_a    = {word_q, lane_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      word_q  <= '0;
      wdat_q  <= '0;
      rbuf_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      wdat_q  <= wdat_d;
      rbuf_q  <= rbuf_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    word_d   = word_q;
    wdat_d   = wdat_q;
    rbuf_d   = rbuf_q;
    sel_d    = sel_q;
    we_d     = we_q;
    oor_d    = oor_q;
    sram_cen = 1'b1;
    sram_wen = 8'hFF;
    sram_d   = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          word_d  = off[SRAM_AW-1:LANE_W];
          wdat_d  = wbs_dat_i;
          sel_d   = wbs_sel_i;
          we_d    = wbs_we_i;
          oor_d   = (off >= WinSize);
          lane_d  = '0;
          rbuf_d  = '0;
          if (off >= WinSize) begin
            state_d = ACK;
          end else if (wbs_we_i) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end

      WR: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          // Deselected lanes still burn their cycle so write latency stays fixed.
          sram_cen = ~sel_q[lane_q];
          sram_wen = sel_q[lane_q] ? 8'h00 : 8'hFF;
          sram_d   = wdat_q[8*lane_q +: 8];
          lane_d   = lane_q + 1'b1;
          if (&lane_q) state_d = ACK;
        end
      end

      RD: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          sram_cen = 1'b0;
          // sram_q carries the byte issued in the previous lane.
          if (lane_q != '0) rbuf_d[8*prev_lane +: 8] = sram_q;
          lane_d = lane_q + 1'b1;
          if (&lane_q) state_d = RD_LAST;
        end
      end

      RD_LAST: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          rbuf_d[31:24] = sram_q;
          state_d       = ACK;
        end
      end

      ACK: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign wbs_dat_o = (state_q == ACK && !we_q && !oor_q) ? rbuf_q : '0;

`ifdef WB_RESP_ERR_EN
  assign wbs_ack_o = (state_q == ACK) && !oor_q;
  assign wbs_err_o = (state_q == ACK) && oor_q;
`else
  assign wbs_ack_o = (state_q == ACK);
  assign wbs_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_sram_responder.sv
// Self-checking bench for wb_sram_responder: directed scenarios plus random traffic checked
// against a byte-array memory model. Honours WB_RESP_ERR_EN when defined.
module tb_wb_sram_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef WB_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o;
  logic        sram_cen;
  logic [7:0]  sram_wen, sram_a, sram_d, sram_q;
  logic        clear = 1'b1;

  logic [7:0]  mem [256];
  logic [7:0]  mdl_mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_sram_responder #(.BASE_ADR(BASE), .SRAM_AW(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_dat_o (wbs_dat_o),
    .wbs_ack_o (wbs_ack_o),
    .wbs_err_o (wbs_err_o),
    .sram_cen  (sram_cen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  // SRAM macro model: bit-masked write, read data one clock after issue.
  always @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (!sram_cen) begin
      if (sram_wen != 8'hFF) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int w);
    return {mdl_mem[4*w+3], mdl_mem[4*w+2], mdl_mem[4*w+1], mdl_mem[4*w]};
  endfunction

  function automatic logic [31:0] sram_word(input int w);
    return {mem[4*w+3], mem[4*w+2], mem[4*w+1], mem[4*w]};
  endfunction

  // One full bus transaction, checked against the memory model.
  task automatic run(input string tag, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] off;
    logic        inr;
    int          w, exp_lat, lat;
    logic [31:0] exp_dat, got_dat;
    logic [3:0]  exp_cen, cen_lanes;
    logic        got_ack, got_err, wen_bad;
    off     = adr - BASE;
    inr     = off < 32'd256;
    w       = int'(off[7:2]);
    exp_lat = !inr ? 1 : (we ? 5 : 6);
    exp_dat = (!we && inr) ? mdl_word(w) : 32'h0;
    exp_cen = !inr ? 4'hF : (we ? ~sel : 4'h0);
    lat = 0; got_dat = 32'h0; got_ack = 0; got_err = 0; cen_lanes = 4'hF; wen_bad = 0;
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_adr_i = adr; wbs_dat_i = dat;
    wbs_sel_i = sel;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 4) cen_lanes[k-1] = sram_cen;
      if (!we && sram_wen !== 8'hFF) wen_bad = 1;
      if (wbs_ack_o || wbs_err_o) begin
        lat = k; got_dat = wbs_dat_o; got_ack = wbs_ack_o; got_err = wbs_err_o;
        break;
      end
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_ack_err"}, {62'h0, got_ack, got_err},
          {62'h0, !(ERR_EN && !inr), ERR_EN && !inr});
    check({tag, "_dat"}, 64'(got_dat), 64'(exp_dat));
    check({tag, "_cen_lanes"}, 64'(cen_lanes), 64'(exp_cen));
    check({tag, "_wen_idle_on_read"}, 64'(wen_bad), 64'h0);
    @(negedge clk);
    check({tag, "_resp_one_cycle"}, {62'h0, wbs_ack_o, wbs_err_o}, 64'h0);
    if (we && inr)
      for (int l = 0; l < 4; l++) if (sel[l]) mdl_mem[4*w+l] = dat[8*l +: 8];
  endtask

  initial begin
    int          bad;
    logic        no_ack;
    logic [31:0] adr;
    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'(i) ^ 8'h5A;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_dat", 64'(wbs_dat_o), 64'h0);
    check("reset_ctl", {37'h0, wbs_ack_o, wbs_err_o, sram_cen, sram_wen, sram_a, sram_d},
          {37'h0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00});
    reset_n = 1;
    @(negedge clk);
    clear = 0;

    // Full-word write then readback
    run("wr_1004", 1'b1, 32'h1004, 32'hA1B2_C3D4, 4'hF);
    check("sram_bytes_4_7", 64'(sram_word(1)), 64'hA1B2_C3D4);
    run("rd_1004", 1'b0, 32'h1004, 32'h0, 4'hF);

    // Partial write onto a preset word
    run("wr_1008_preset", 1'b1, 32'h1008, 32'hFFFF_FFFF, 4'hF);
    run("wr_1008_sel5", 1'b1, 32'h1008, 32'h1122_3344, 4'b0101);
    check("sram_word_2", 64'(sram_word(2)), 64'hFF22_FF44);
    run("rd_1008", 1'b0, 32'h1008, 32'h0, 4'hF);

    // Window top, then just past it, then below the base
    run("wr_10fc", 1'b1, 32'h10FC, 32'hDEAD_BEEF, 4'hF);
    check("sram_word_63", 64'(sram_word(63)), 64'hDEAD_BEEF);
    run("rd_1100", 1'b0, 32'h1100, 32'h0, 4'hF);
    run("wr_1100", 1'b1, 32'h1100, 32'h1234_5678, 4'hF);
    run("rd_0ffc", 1'b0, 32'h0FFC, 32'h0, 4'hF);
    run("wr_sel0", 1'b1, 32'h1010, 32'h9999_9999, 4'h0);

    // Abort during write lane 2
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 32'h1000;
    wbs_dat_i = 32'h5566_7788; wbs_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);
    check("abort_lane2_cen", 64'(sram_cen), 64'h1);
    no_ack = 1;
    repeat (6) begin
      @(negedge clk);
      if (wbs_ack_o || wbs_err_o) no_ack = 0;
    end
    check("abort_no_ack", 64'(no_ack), 64'h1);
    mdl_mem[0] = 8'h88;
    mdl_mem[1] = 8'h77;
    check("abort_bytes", 64'(sram_word(0)), 64'(mdl_word(0)));
    run("rd_after_abort", 1'b0, 32'h1000, 32'h0, 4'hF);

    // Asynchronous reset mid-read
    @(negedge clk);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h1004; wbs_sel_i = 4'hF;
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("midrd_reset_dat", 64'(wbs_dat_o), 64'h0);
    check("midrd_reset_ctl", {37'h0, wbs_ack_o, wbs_err_o, sram_cen, sram_wen, sram_a, sram_d},
          {37'h0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 8'h00});
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);
    reset_n = 1;
    run("rd_after_reset", 1'b0, 32'h1004, 32'h0, 4'hF);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0:       adr = BASE - 32'($urandom_range(1, 64));
        1:       adr = BASE + 32'd256 + 32'($urandom_range(0, 1000));
        default: adr = BASE + 32'($urandom_range(0, 255));
      endcase
      run("rand", 1'($urandom), adr, $urandom, 4'($urandom));
    end

    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== mdl_mem[i]) bad++;
    check("final_mem_image", 64'(bad), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
